// File: rtl/idct_job_scheduler.sv
// rtl/idct_job_scheduler.sv - round-robin job scheduler for a shared 2-D IDCT engine
module idct_job_scheduler #(
  parameter int N       = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [TAG_W-1:0]  req_tag0,
  input  logic [TAG_W-1:0]  req_tag1,
  input  logic [N*N*16-1:0] req_coef0,
  input  logic [N*N*16-1:0] req_coef1,
  output logic              eng_start,
  output logic [N*N*16-1:0] eng_x,
  input  logic              eng_done,
  input  logic [N*N*16-1:0] eng_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [N*N*16-1:0] out_coef,
  output logic              busy,
  output logic [15:0]       jobs_done
);
  localparam int BLK_W = N*N*16;
  // The counter only has to reach TIMEOUT-1 before the job is aborted.
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic [WD_W-1:0]   r_wd;
  logic              r_eng_start;
  logic [BLK_W-1:0]  r_eng_x;
  logic              r_out_valid;
  logic              r_out_src;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_err;
  logic [BLK_W-1:0]  r_out_coef;
  logic [15:0]       r_jobs_done;

  logic              w_grant;
  logic              w_accept;
  logic              w_active;
  logic              w_complete;
  logic              w_timeout;
  logic              w_out_hs;

  // Round-robin pick: with both valid, the requester not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && (req_valid != 2'b00);
  assign req_ready  = {w_accept & w_grant, w_accept & ~w_grant};
  assign w_active   = (r_state == S_ARM) || (r_state == S_RUN);
  // A completion only counts once the stale done of the previous job has dropped.
  assign w_complete = (r_state == S_RUN) && eng_done;
  assign w_timeout  = w_active && (r_wd == WD_W'(TIMEOUT - 1)) && !w_complete;
  assign w_out_hs   = (r_state == S_OUT) && out_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic for the job sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_ARM;
      S_ARM: begin
        if (w_timeout)     w_next_state = S_OUT;
        else if (!eng_done) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_complete)     w_next_state = S_OUT;
        else if (w_timeout) w_next_state = S_OUT;
      end
      S_OUT: if (w_out_hs) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job datapath: latch on accept, capture or abort at the end, retire on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_wd         <= '0;
      r_eng_start  <= 1'b0;
      r_eng_x      <= '0;
      r_out_valid  <= 1'b0;
      r_out_src    <= 1'b0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
      r_out_coef   <= '0;
      r_jobs_done  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_eng_x      <= w_grant ? req_coef1 : req_coef0;
        r_out_tag    <= w_grant ? req_tag1 : req_tag0;
        r_out_src    <= w_grant;
        r_last_grant <= w_grant;
        r_wd         <= '0;
        r_eng_start  <= 1'b1;
      end
      if (w_active) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_complete) begin
        r_out_coef  <= eng_y;
        r_out_err   <= 1'b0;
        r_eng_start <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (w_timeout) begin
        r_out_coef  <= '0;
        r_out_err   <= 1'b1;
        r_eng_start <= 1'b0;
        r_out_valid <= 1'b1;
      end
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_jobs_done <= r_jobs_done + 16'd1;
      end
    end
  end

  assign eng_start = r_eng_start;
  assign eng_x     = r_eng_x;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;
  assign out_coef  = r_out_coef;
  assign busy      = (r_state != S_IDLE);
  assign jobs_done = r_jobs_done;

endmodule

// File: tb/tb_idct_job_scheduler.sv
// tb/tb_idct_job_scheduler.sv - self-checking bench for idct_job_scheduler
module tb_idct_job_scheduler;
  localparam int N       = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 100;
  localparam int BW      = N*N*16;
  localparam int ENG_LAT = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [TAG_W-1:0]  req_tag0 = '0;
  logic [TAG_W-1:0]  req_tag1 = '0;
  logic [BW-1:0]     req_coef0 = '0;
  logic [BW-1:0]     req_coef1 = '0;
  logic              eng_start;
  logic [BW-1:0]     eng_x;
  logic              eng_done;
  logic [BW-1:0]     eng_y;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_src;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [BW-1:0]     out_coef;
  logic              busy;
  logic [15:0]       jobs_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_jobs = 16'd0;
  logic eng_hang = 1'b0;

  typedef struct {
    logic [1:0]       mask;
    logic [TAG_W-1:0] tag0;
    logic [TAG_W-1:0] tag1;
    logic [15:0]      dc0;
    logic [15:0]      dc1;
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [15:0]      dc;
  } job_t;

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [BW-1:0]    coef;
  } exp_t;

  exp_t sb[$];

  idct_job_scheduler #(.N(N), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .req_coef0(req_coef0), .req_coef1(req_coef1),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_y(eng_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_tag(out_tag), .out_err(out_err), .out_coef(out_coef),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] bcast(input logic [15:0] d);
    logic [BW-1:0] b;
    for (int i = 0; i < N*N; i++) b[i*16 +: 16] = d;
    return b;
  endfunction

  function automatic logic [BW-1:0] dc_blk(input logic [15:0] d);
    logic [BW-1:0] b;
    b = '0;
    b[15:0] = d;
    return b;
  endfunction

  // Behavioural engine for DC-only blocks: every output element equals the DC input.
  // done stays high after a job until a new start is sampled in idle.
  typedef enum logic [1:0] {E_IDLE, E_BUSY, E_DONE} eng_st_t;
  eng_st_t e_st;
  int      e_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_st     <= E_IDLE;
      e_cnt    <= 0;
      eng_done <= 1'b0;
      eng_y    <= '0;
    end else begin
      case (e_st)
        E_IDLE: if (eng_start) begin
          eng_done <= 1'b0;
          e_cnt    <= ENG_LAT;
          e_st     <= E_BUSY;
        end
        E_BUSY: if (!eng_hang) begin
          if (e_cnt == 0) begin
            eng_done <= 1'b1;
            eng_y    <= bcast(eng_x[15:0]);
            e_st     <= E_DONE;
          end else begin
            e_cnt <= e_cnt - 1;
          end
        end
        default: if (!eng_start) e_st <= E_IDLE;
      endcase
    end
  end

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ctl"}, BW'({req_ready, eng_start, out_valid, out_src, out_tag, out_err, busy, jobs_done}), '0);
    check({nm, "_eng_x"}, eng_x, '0);
    check({nm, "_out_coef"}, out_coef, '0);
  endtask

  // Present one job, wait for its grant, queue its expected result, return after acceptance.
  task automatic run_job(input job_t r);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = r.mask;
    req_tag0  = r.tag0;
    req_tag1  = r.tag1;
    req_coef0 = dc_blk(r.dc0);
    req_coef1 = dc_blk(r.dc1);
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", BW'(req_ready), BW'(r.src ? 2'b10 : 2'b01));
    if (req_ready == 2'b00) return;
    e.src  = r.src;
    e.tag  = r.tag;
    e.err  = r.err;
    e.coef = r.err ? '0 : bcast(r.dc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("start_at_accept", BW'({eng_start, busy, req_ready}), BW'(4'b1100));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("out_valid_seen", BW'(out_valid), BW'(1'b1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", BW'(sb.size()), '0);
  endtask

  // Output scoreboard and req_ready sanity monitor.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!reset && req_ready != 2'b00) begin
      check("ready_only_idle", BW'(busy), '0);
      check("ready_onehot", BW'(req_ready == 2'b01 || req_ready == 2'b10), BW'(1'b1));
    end
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0h src %0d expected no output", out_tag, out_src);
      end else begin
        e = sb.pop_front();
        check("out_src", BW'(out_src), BW'(e.src));
        check("out_tag", BW'(out_tag), BW'(e.tag));
        check("out_err", BW'(out_err), BW'(e.err));
        check("out_coef", out_coef, e.coef);
        check("start_low_at_out", BW'(eng_start), '0);
      end
      exp_jobs = exp_jobs + 16'd1;
      @(negedge clk);
      #2;
      check("jobs_done", BW'(jobs_done), BW'(exp_jobs));
    end
  end

  job_t tbl[9];
  job_t bp_job, wd_job, rec_job;

  initial begin
    int n;
    //          mask   t0 t1 dc0          dc1           src tag err dc
    tbl[0] = '{2'b11, 1, 2, 16'd10,      16'd20,       0,  1, 0, 16'd10};
    tbl[1] = '{2'b11, 3, 4, 16'd30,      16'd40,       1,  4, 0, 16'd40};
    tbl[2] = '{2'b11, 6, 7, 16'd50,      16'd60,       0,  6, 0, 16'd50};
    tbl[3] = '{2'b11, 8, 9, 16'hfffb,    16'd70,       1,  9, 0, 16'd70};
    tbl[4] = '{2'b01, 5, 0, 16'd64,      16'd0,        0,  5, 0, 16'd64};
    tbl[5] = '{2'b10, 0, 10, 16'd0,      16'hfed4,     1, 10, 0, 16'hfed4};
    tbl[6] = '{2'b10, 0, 11, 16'd0,      16'd7,        1, 11, 0, 16'd7};
    tbl[7] = '{2'b01, 12, 0, 16'd1,      16'd0,        0, 12, 0, 16'd1};
    tbl[8] = '{2'b11, 13, 14, 16'd100,   16'd200,      1, 14, 0, 16'd200};
    bp_job  = '{2'b11, 2, 3, 16'd11,     16'd22,       0,  2, 0, 16'd11};
    wd_job  = '{2'b01, 15, 0, 16'd99,    16'd0,        0, 15, 1, 16'd0};
    rec_job = '{2'b11, 1, 2, 16'd5,      16'd6,        0,  1, 0, 16'd5};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check_reset_vals("idle_reset");
    end

    // Arbitration, single DC job and back-to-back jobs against a stale done.
    for (int i = 0; i < 9; i++) run_job(tbl[i]);
    req_valid = 2'b00;
    wait_drain();

    // Backpressure: result frozen and no new grant while out_ready is low.
    out_ready = 1'b0;
    run_job(bp_job);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_ctl", BW'({out_valid, out_src, out_tag, out_err, req_ready}), BW'({1'b1, 1'b0, 4'd2, 1'b0, 2'b00}));
      check("bp_coef", out_coef, bcast(16'd11));
    end
    @(negedge clk);
    req_valid = 2'b00;
    out_ready = 1'b1;
    wait_drain();
    check("bp_one_handshake", BW'(jobs_done), BW'(16'd10));

    // Watchdog: hung engine aborts after TIMEOUT cycles in ARM+RUN.
    eng_hang = 1'b1;
    run_job(wd_job);
    req_valid = 2'b00;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wd_cycles", BW'(n), BW'(TIMEOUT));
    check("wd_state", BW'({eng_start, out_err, out_valid}), BW'(3'b011));
    wait_drain();
    check("wd_jobs", BW'(jobs_done), BW'(16'd11));

    // Second job on the hung engine, then asynchronous reset mid-RUN.
    @(negedge clk);
    req_valid = 2'b10;
    req_tag1  = 4'd6;
    req_coef1 = dc_blk(16'd33);
    #1;
    check("midrun_grant", BW'(req_ready), BW'(2'b10));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrun_busy", BW'({busy, eng_start, out_valid}), BW'(3'b110));
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("midrun_reset");
    exp_jobs = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    eng_hang = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_empty", BW'({out_valid, busy}), '0);

    // Recovery: grant restarts from requester 0.
    run_job(rec_job);
    req_valid = 2'b00;
    wait_drain();
    check("rec_jobs", BW'(jobs_done), BW'(16'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
